alu_writeback_stage: RTL
========================

Name: alu_writeback_stage

Overview:
Downstream stage of the 8-bit ALU. It captures the ALU result, flags (cr, ov, ng, zr) and destination tag through a valid/ready handshake. It buffers them in a 2-entry skid buffer and presents them to the register-file write port. It also owns the architectural status register {C,V,N,Z} and evaluates branch conditions against it for the control unit.

Parameters:
DATA_W, 8, width of the ALU result and writeback data.
RD_W, 3, width of the destination-register index (8 GPRs).

Ports:
clk  input  1  system clock
rst  input  1  reset, synchronous, active-high
in_valid  input  1  upstream has an ALU result this cycle
in_ready  output  1  stage can accept a result
alu_out  input  DATA_W  ALU result
cr  input  1  ALU carry flag
ov  input  1  ALU overflow flag
ng  input  1  ALU negative flag
zr  input  1  ALU zero flag
operation  input  4  ALU opcode for this result
rd  input  RD_W  destination register index
rd_we  input  1  result is to be written to the register file
flag_we  input  1  result updates the status register
wb_valid  output  1  writeback entry presented
wb_ready  input  1  register file accepts the entry
wb_data  output  DATA_W  writeback data
wb_rd  output  RD_W  writeback register index
wb_we  output  1  writeback write-enable (qualified by wb_valid)
status  output  4  {C,V,N,Z}
cond_sel  input  3  branch condition select
cond_true  output  1  selected condition holds

Behaviour:
- Interface: one clock (clk). Reset rst is synchronous and active-high.
- Reset: wb_valid=0, in_ready=1, wb_data=0, wb_rd=0, wb_we=0, status=4'b0000, both buffer entries invalid. Reset asserted mid-transfer discards all buffered entries. No writeback is issued for them.
- Accept: a transfer occurs when in_valid && in_ready at a rising edge. Drain: a transfer occurs when wb_valid && wb_ready.
- Buffer: main register plus skid register, registered outputs driven from main.
  - Empty: an accept loads main. wb_valid=1 in the next cycle, so latency is 1 cycle.
  - Main valid, drain, no accept: main is cleared.
  - Main valid, drain and accept in the same cycle: main is loaded with the new entry. Throughput is 1 per cycle.
  - Main valid, no drain, accept: the entry goes to skid. in_ready=0 from the next cycle.
  - Skid full, drain: skid moves to main and in_ready returns to 1 in the next cycle.
- in_ready = !skid_valid, registered. It is never combinationally dependent on wb_ready.
- Ordering: entries drain strictly in accept order. No entry is dropped or duplicated.
- wb_* outputs hold stable while wb_valid && !wb_ready.
- Status update: happens at the accept edge, not at writeback, and only if flag_we=1.
  - N and Z are always loaded from ng and zr.
  - C and V are loaded from cr and ov only when operation is ADD (4'b0010) or SUB (4'b0110). Otherwise C and V retain their previous values.
  - flag_we=0 leaves status unchanged.
- cond_true is combinational from the status register:
  - 000 always 1
  - 001 EQ (Z)
  - 010 NE (!Z)
  - 011 CS (C)
  - 100 CC (!C)
  - 101 MI (N)
  - 110 VS (V)
  - 111 LT (N^V)
- Entries with rd_we=0 still pass through the buffer and are presented with wb_we=0. This keeps ordering and handshake uniform.

Optional Feature:
FLAG_FWD_EN.
- Defined: when an accept with flag_we=1 occurs in the current cycle, cond_true is computed from the incoming flags, merged under the same C/V retention rule. The control unit can therefore branch on flags produced in the same cycle.
- Undefined: cond_true reflects only the registered status. A branch sees new flags one cycle after the accept.
- Registered status contents are identical in both builds.

Test Plan:
1. Reset, then accept alu_out=8'h3C, rd=5, rd_we=1, wb_ready=1 -> next cycle wb_valid=1, wb_data=8'h3C, wb_rd=5, wb_we=1. The cycle after that, wb_valid=0.
2. Hold wb_ready=0 and send 3 back-to-back entries (8'h01, 8'h02, 8'h03) -> first two accepted and in_ready=0. Then raise wb_ready -> outputs 01, 02, 03 in order, and the third is accepted once in_ready=1.
3. ADD with flag_we=1, cr=1, ov=0, ng=0, zr=0 -> status=4'b1000. Then AND with flag_we=1, zr=1, ng=0, cr=0 -> status=4'b1001 (C retained).
4. Status N=1, V=0 -> cond_sel=111 gives cond_true=1, cond_sel=110 gives 0, cond_sel=000 gives 1.
5. Assert rst with both buffer entries full -> next cycle wb_valid=0, in_ready=1, status=0. No stale entry appears afterwards.
6. With FLAG_FWD_EN defined, status Z=0, SUB accept with zr=1 and cond_sel=001 -> cond_true=1 in the same cycle. Undefined: cond_true=0 in that cycle and 1 in the next.

Source files
------------

// File: rtl/alu_writeback_stage.sv
// alu_writeback_stage: 2-entry skid-buffered ALU writeback with status register and branch conditions; define FLAG_FWD_EN to forward accepted flags into cond_true.
module alu_writeback_stage #(
  parameter int DATA_W = 8,
  parameter int RD_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              cr,
  input  logic              ov,
  input  logic              ng,
  input  logic              zr,
  input  logic [3:0]        operation,
  input  logic [RD_W-1:0]   rd,
  input  logic              rd_we,
  input  logic              flag_we,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [DATA_W-1:0] wb_data,
  output logic [RD_W-1:0]   wb_rd,
  output logic              wb_we,
  output logic [3:0]        status,
  input  logic [2:0]        cond_sel,
  output logic              cond_true
);
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  logic              main_v, main_we, skid_v, skid_we, acc, drn, arith;
  logic [DATA_W-1:0] main_data, skid_data;
  logic [RD_W-1:0]   main_rd, skid_rd;
  logic [3:0]        nxt_status, eff_status;
  logic [7:0]        conds;
  assign acc = in_valid && in_ready;
  assign drn = main_v && wb_ready;
  assign in_ready = !skid_v;
  assign wb_valid = main_v;
  assign wb_we = main_v && main_we;
  assign wb_data = main_data;
  assign wb_rd = main_rd;
  assign arith = (operation == OP_ADD) || (operation == OP_SUB);
  // status bits are {C,V,N,Z}; C/V only move on add/sub
  assign nxt_status = {arith ? cr : status[3], arith ? ov : status[2], ng, zr};
  always_ff @(posedge clk) begin
    if (rst) begin
      main_v <= 1'b0;
      main_we <= 1'b0;
      main_data <= '0;
      main_rd <= '0;
      skid_v <= 1'b0;
      skid_we <= 1'b0;
      skid_data <= '0;
      skid_rd <= '0;
      status <= 4'b0000;
    end else begin
      if (!main_v || drn) begin
        if (skid_v) begin
          main_v <= 1'b1;
          main_we <= skid_we;
          main_data <= skid_data;
          main_rd <= skid_rd;
          skid_v <= 1'b0;
        end else begin
          main_v <= acc;
          if (acc) begin
            main_we <= rd_we;
            main_data <= alu_out;
            main_rd <= rd;
          end
        end
      end else if (acc) begin
        skid_v <= 1'b1;
        skid_we <= rd_we;
        skid_data <= alu_out;
        skid_rd <= rd;
      end
      if (acc && flag_we) status <= nxt_status;
    end
  end
`ifdef FLAG_FWD_EN
  assign eff_status = (acc && flag_we) ? nxt_status : status;
`else
  assign eff_status = status;
`endif
  assign conds = {eff_status[1] ^ eff_status[2], eff_status[2], eff_status[1], !eff_status[3],
                  eff_status[3], !eff_status[0], eff_status[0], 1'b1};
  assign cond_true = conds[cond_sel];
endmodule
